gda_accuracy_ctrl: RTL and testbench

Sequencing controller wrapped around one instance of the team's gracefully-degrading adder (gda). It accepts operand transactions over a valid/ready handshake and drives the gda per-boundary control bits, one evaluation pass per cycle. In ADAPTIVE mode it starts fully approximate, then enables exact carry only at boundaries flagged as risky, until the result is provably exact or the pass budget runs out. It sits between an operand source and a result consumer in approximate-arithmetic datapaths.

---
 rtl/gda_ctrl_pkg.sv | 17 +
 rtl/gda.sv | 39 +++
 rtl/gda_risk_detect.sv | 16 +
 rtl/gda_accuracy_ctrl.sv | 147 ++++++++++++++
 tb/tb_gda_accuracy_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/gda_ctrl_pkg.sv
// Shared encodings for the gda accuracy controller: operand modes, FSM states
// and the width of the evaluation-pass counter.
package gda_ctrl_pkg;

    localparam logic [1:0] MODE_APPROX   = 2'd0;
    localparam logic [1:0] MODE_EXACT    = 2'd1;
    localparam logic [1:0] MODE_ADAPTIVE = 2'd2;

    localparam int PASS_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/gda.sv
// Gracefully-degrading adder: SUBSIZE-bit segments; at each boundary the carry is
// either the true ripple carry (control=1) or the segment's own generate (control=0).
module gda #(
    parameter int SIZE    = 16,
    parameter int SUBSIZE = 4,
    parameter int NB      = SIZE / SUBSIZE - 1
) (
    input  logic [SIZE:1] a,
    input  logic [SIZE:1] b,
    input  logic          cin,
    input  logic [NB:1]   control,
    output logic [SIZE:1] sum,
    output logic          cout
);

    for (genvar s = 1; s <= NB + 1; s++) begin : g_seg
        logic [SUBSIZE:0] full;
        logic             c_in;
        logic             co_full;
        logic             co_zero;

        if (s == 1) begin : g_first
            assign c_in = cin;
        end else begin : g_rest
            assign c_in = control[s-1] ? g_seg[s-1].co_full : g_seg[s-1].co_zero;
        end

        assign full = {1'b0, a[s*SUBSIZE -: SUBSIZE]} + {1'b0, b[s*SUBSIZE -: SUBSIZE]}
                    + {{SUBSIZE{1'b0}}, c_in};
        assign sum[s*SUBSIZE -: SUBSIZE] = full[SUBSIZE-1:0];
        assign co_full = full[SUBSIZE];
        // With carry-in 0 an all-propagate segment cannot carry out; otherwise the
        // carry-out does not depend on carry-in at all.
        assign co_zero = co_full & ~(&(a[s*SUBSIZE -: SUBSIZE] ^ b[s*SUBSIZE -: SUBSIZE]));
    end

    assign cout = g_seg[NB+1].co_full;

endmodule

// File: rtl/gda_risk_detect.sv
// Flags boundary k as risky when the segment feeding it is all-propagate, the only
// case where the approximate carry can differ from the exact one.
module gda_risk_detect #(
    parameter int SUBSIZE = 4,
    parameter int NB      = 3
) (
    input  logic [NB*SUBSIZE:1] a_i,
    input  logic [NB*SUBSIZE:1] b_i,
    output logic [NB:1]         risk_o
);

    for (genvar k = 1; k <= NB; k++) begin : g_bnd
        assign risk_o[k] = &(a_i[k*SUBSIZE -: SUBSIZE] ^ b_i[k*SUBSIZE -: SUBSIZE]);
    end

endmodule

// File: rtl/gda_accuracy_ctrl.sv
// Sequences one gda per transaction: one evaluation pass per cycle, in adaptive mode
// enabling exact carry on risky boundaries until exact or out of passes.
module gda_accuracy_ctrl
    import gda_ctrl_pkg::*;
#(
    parameter int SIZE       = 16,
    parameter int SUBSIZE    = 4,
    parameter int BUDGET     = 1,
    parameter int MAX_PASSES = 3,
    localparam int NB        = SIZE / SUBSIZE - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   in_a,
    input  logic [SIZE-1:0]   in_b,
    input  logic              in_cin,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIZE-1:0]   out_sum,
    output logic              out_cout,
    output logic              out_exact,
    output logic [PASS_W-1:0] out_passes,
    output logic [NB-1:0]     gda_control
);

    state_t              state_q, state_d;
    logic [SIZE-1:0]     a_q, b_q;
    logic                cin_q;
    logic [1:0]          mode_q;
    logic [NB-1:0]       ctrl_q, ctrl_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [SIZE-1:0]     sum_q;
    logic                cout_q, exact_q;
    logic [PASS_W-1:0]   passes_q;

    logic [SIZE-1:0]     gda_sum;
    logic                gda_cout;
    logic [NB-1:0]       risk, pending, grant;
    logic                eval_done;

    gda #(.SIZE(SIZE), .SUBSIZE(SUBSIZE), .NB(NB)) u_gda (
        .a       (a_q),
        .b       (b_q),
        .cin     (cin_q),
        .control (ctrl_q),
        .sum     (gda_sum),
        .cout    (gda_cout)
    );

    gda_risk_detect #(.SUBSIZE(SUBSIZE), .NB(NB)) u_risk (
        .a_i    (a_q[NB*SUBSIZE-1:0]),
        .b_i    (b_q[NB*SUBSIZE-1:0]),
        .risk_o (risk)
    );

    // Lowest-indexed pending boundaries, at most BUDGET of them per pass.
    always_comb begin
        int cnt;
        pending = risk & ~ctrl_q;
        grant   = '0;
        cnt     = 0;
        for (int k = 0; k < NB; k++) begin
            if (pending[k] && cnt < BUDGET) begin
                grant[k] = 1'b1;
                cnt      = cnt + 1;
            end
        end
        eval_done = (mode_q != MODE_ADAPTIVE) || (pending == '0)
                 || (pass_q == PASS_W'(MAX_PASSES));
    end

    always_comb begin
        ctrl_d = ctrl_q;
        pass_d = pass_q;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                ctrl_d = (in_mode == MODE_APPROX || in_mode == MODE_ADAPTIVE) ? '0 : '1;
                pass_d = PASS_W'(1);
            end
            ST_EVAL: if (!eval_done) begin
                ctrl_d = ctrl_q | grant;
                pass_d = pass_q + PASS_W'(1);
            end
            ST_HOLD: if (out_ready) ctrl_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_EVAL;
            ST_EVAL: if (eval_done) state_d = ST_HOLD;
            ST_HOLD: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == ST_IDLE);
        out_valid   = (state_q == ST_HOLD);
        out_sum     = sum_q;
        out_cout    = cout_q;
        out_exact   = exact_q;
        out_passes  = passes_q;
        gda_control = ctrl_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            mode_q   <= MODE_APPROX;
            ctrl_q   <= '0;
            pass_q   <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            exact_q  <= 1'b0;
            passes_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            pass_q <= pass_d;
            if (state_q == ST_IDLE && in_valid) begin
                a_q    <= in_a;
                b_q    <= in_b;
                cin_q  <= in_cin;
                mode_q <= in_mode;
            end
            if (state_q == ST_EVAL && eval_done) begin
                sum_q    <= gda_sum;
                cout_q   <= gda_cout;
                exact_q  <= (pending == '0);
                passes_q <= pass_q;
            end
        end
    end

endmodule

// File: tb/tb_gda_accuracy_ctrl.sv
// Directed bench for gda_accuracy_ctrl (SIZE=16, SUBSIZE=4, BUDGET=1, MAX_PASSES=3).
module tb_gda_accuracy_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic [1:0]  in_mode = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_exact;
    logic [3:0]  out_passes;
    logic [2:0]  gda_control;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gda_accuracy_ctrl #(.SIZE(16), .SUBSIZE(4), .BUDGET(1), .MAX_PASSES(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cin      (in_cin),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_cout    (out_cout),
        .out_exact   (out_exact),
        .out_passes  (out_passes),
        .gda_control (gda_control)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [1:0] mode);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_mode  = mode;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int n = 0;
        while (out_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, ".ctrl_clear"}, 32'(gda_control), 32'd0);
    endtask

    task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic [1:0] mode,
                           input logic [15:0] e_sum, input logic e_cout, input logic e_exact,
                           input int e_passes, input logic [2:0] e_ctrl);
        send(tag, a, b, cin, mode);
        wait_out(tag, e_passes);
        chk({tag, ".sum"},    32'(out_sum),     32'(e_sum));
        chk({tag, ".cout"},   32'(out_cout),    32'(e_cout));
        chk({tag, ".exact"},  32'(out_exact),   32'(e_exact));
        chk({tag, ".passes"}, 32'(out_passes),  32'(e_passes));
        chk({tag, ".ctrl"},   32'(gda_control), 32'(e_ctrl));
        release_out(tag);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst.out_valid", 32'(out_valid),   32'd0);
        chk("rst.in_ready",  32'(in_ready),    32'd1);
        chk("rst.sum",       32'(out_sum),     32'd0);
        chk("rst.cout",      32'(out_cout),    32'd0);
        chk("rst.exact",     32'(out_exact),   32'd0);
        chk("rst.passes",    32'(out_passes),  32'd0);
        chk("rst.ctrl",      32'(gda_control), 32'd0);

        run_txn("t1_approx",   16'h00FF, 16'h0001, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1, 3'b000);
        run_txn("t2_adaptive", 16'h00FF, 16'h0001, 1'b0, 2'd2, 16'h0100, 1'b0, 1'b1, 2, 3'b010);
        run_txn("t3_exact",    16'h00FF, 16'h0001, 1'b0, 2'd1, 16'h0100, 1'b0, 1'b1, 1, 3'b111);
        run_txn("t4_budget",   16'hFFFF, 16'h0000, 1'b1, 2'd2, 16'hF000, 1'b0, 1'b0, 3, 3'b011);
        run_txn("t_norisk",    16'h1234, 16'h0001, 1'b0, 2'd2, 16'h1235, 1'b0, 1'b1, 1, 3'b000);
        run_txn("t_mode3",     16'h00FF, 16'h0001, 1'b0, 2'd3, 16'h0100, 1'b0, 1'b1, 1, 3'b111);

        // Backpressure: hold the result while a new transaction waits at the input.
        send("t5", 16'h00FF, 16'h0001, 1'b0, 2'd0);
        wait_out("t5", 1);
        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_b     = 16'h0000;
        in_cin   = 1'b1;
        in_mode  = 2'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5.hold_valid", 32'(out_valid), 32'd1);
            chk("t5.hold_ready", 32'(in_ready),  32'd0);
            chk("t5.hold_sum",   32'(out_sum),   32'h0000);
            chk("t5.hold_cout",  32'(out_cout),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5.idle_valid", 32'(out_valid), 32'd0);
        chk("t5.idle_ready", 32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        chk("t5.accepted", 32'(in_ready), 32'd0);
        wait_out("t5b", 1);
        chk("t5b.sum",   32'(out_sum),     32'h0000);
        chk("t5b.cout",  32'(out_cout),    32'd1);
        chk("t5b.exact", 32'(out_exact),   32'd1);
        chk("t5b.ctrl",  32'(gda_control), 32'd7);
        release_out("t5b");

        // Reset during the second adaptive pass drops the transaction.
        send("t6", 16'hFFFF, 16'h0000, 1'b1, 2'd2);
        chk("t6.pass1_ctrl", 32'(gda_control), 32'd0);
        tick();
        chk("t6.pass2_ctrl", 32'(gda_control), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6.valid",    32'(out_valid),   32'd0);
        chk("t6.in_ready", 32'(in_ready),    32'd1);
        chk("t6.ctrl",     32'(gda_control), 32'd0);
        chk("t6.cout",     32'(out_cout),    32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        chk("t6.no_result", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
